// File: rtl/fp_norm_round32_if.sv
// Data/handshake bundle for fp_norm_round32.
//   ce       : clock enable, low freezes the whole pipeline
//   vld_i    : input word valid
//   i[56:0]  : {sign, biased exponent[7:0], mantissa[47:0]} (m[47:46] integer bits)
//   over_i   : upstream exponent overflow
//   under_i  : upstream exponent underflow
//   rm[2:0]  : rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 RNE)
//   o[31:0]  : IEEE-754 single result
//   vld_o    : o and flags valid
//   overflow, underflow, inexact : IEEE status flags for o
interface fp_norm_round32_if;
  logic        ce;
  logic        vld_i;
  logic [56:0] i;
  logic        over_i;
  logic        under_i;
  logic [2:0]  rm;
  logic [31:0] o;
  logic        vld_o;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  modport master (
    output ce, vld_i, i, over_i, under_i, rm,
    input  o, vld_o, overflow, underflow, inexact
  );

  modport slave (
    input  ce, vld_i, i, over_i, under_i, rm,
    output o, vld_o, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_norm_round32.sv
// Normalise and round an expanded floating-point product to IEEE-754 single.
// Three-stage pipeline: classify + leading-zero count, normalise, round/pack.
//   DENORM   : 1 = produce denormal results, 0 = flush them to signed zero
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears every pipeline register
//   bus      : fp_norm_round32_if.slave (inputs, result and flags)
module fp_norm_round32 #(
  parameter int unsigned DENORM = 1
) (
  input logic          clk,
  input logic          rst,
  fp_norm_round32_if.slave bus
);

  localparam int unsigned EW = 8;   // exponent field
  localparam int unsigned MW = 48;  // expanded mantissa
  localparam int unsigned FW = 23;  // IEEE fraction
  localparam int unsigned XW = 10;  // internal exponent, wide enough to never wrap

  localparam logic [1:0] CLS_NORMAL  = 2'd0;
  localparam logic [1:0] CLS_ZERO    = 2'd1;
  localparam logic [1:0] CLS_FLUSH   = 2'd2;
  localparam logic [1:0] CLS_SPECIAL = 2'd3;

  typedef struct packed {
    logic          vld;
    logic          sign;
    logic [2:0]    rm;
    logic [1:0]    cls;
    logic          over;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    logic [5:0]    lz;
  } s1_t;

  typedef struct packed {
    logic          vld;
    logic          sign;
    logic [2:0]    rm;
    logic [1:0]    cls;
    logic          over;
    logic [XW-1:0] ex;
    logic [FW-1:0] frac;
    logic          guard;
    logic          sticky;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  logic [31:0] o_d, o_q;
  logic        ov_d, ov_q;
  logic        un_d, un_q;
  logic        ix_d, ix_q;
  logic        vld_q;

  // Leading-zero count of the mantissa; 48 when the mantissa is zero.
  function automatic logic [5:0] lzc(input logic [MW-1:0] v);
    logic [5:0] n;
    n = 6'(MW);
    for (int unsigned k = 0; k < MW; k++) begin
      if (v[k]) n = 6'(MW - 1 - k);
    end
    return n;
  endfunction

  // Stage 1: classify and count leading zeros; e==0 is treated as e==1.
  always_comb begin
    s1_d      = '0;
    s1_d.vld  = bus.vld_i;
    s1_d.sign = bus.i[56];
    s1_d.rm   = bus.rm;
    s1_d.over = bus.over_i;
    s1_d.e    = (bus.i[55:48] == '0) ? 8'd1 : bus.i[55:48];
    s1_d.m    = bus.i[47:0];
    s1_d.lz   = lzc(bus.i[47:0]);
    if (bus.i[55:48] == 8'hFF || bus.over_i) begin
      s1_d.cls = CLS_SPECIAL;
    end else if (bus.i[47:0] == '0) begin
      s1_d.cls = CLS_ZERO;
    end else if (bus.under_i) begin
      s1_d.cls = CLS_FLUSH;
    end else begin
      s1_d.cls = CLS_NORMAL;
    end
  end

  // Stage 2: align the leading one to bit 46, limited so the exponent stays >= 1.
  logic [EW-1:0] lzm1;
  logic [EW-1:0] em1;
  logic [EW-1:0] sh;
  logic [MW-2:0] shl;

  always_comb begin
    lzm1 = 8'(s1_q.lz) - 8'd1;
    em1  = s1_q.e - 8'd1;
    sh   = (lzm1 < em1) ? lzm1 : em1;
    // Only used when m[47:46]==0, so bit 47 carries nothing.
    shl  = s1_q.m[MW-2:0] << sh;

    s2_d      = '0;
    s2_d.vld  = s1_q.vld;
    s2_d.sign = s1_q.sign;
    s2_d.rm   = s1_q.rm;
    s2_d.cls  = s1_q.cls;
    s2_d.over = s1_q.over;

    if (s1_q.cls == CLS_SPECIAL) begin
      s2_d.ex   = 10'd255;
      s2_d.frac = s1_q.m[46:24];
    end else if (s1_q.m[47]) begin
      s2_d.ex     = 10'(s1_q.e) + 10'd1;
      s2_d.frac   = s1_q.m[46:24];
      s2_d.guard  = s1_q.m[23];
      s2_d.sticky = |s1_q.m[22:0];
    end else if (s1_q.m[46]) begin
      s2_d.ex     = 10'(s1_q.e);
      s2_d.frac   = s1_q.m[45:23];
      s2_d.guard  = s1_q.m[22];
      s2_d.sticky = |s1_q.m[21:0];
    end else begin
      // Shift stopped at exponent 1 without reaching bit 46: denormal field 0.
      s2_d.ex     = shl[46] ? (10'(s1_q.e) - 10'(sh)) : 10'd0;
      s2_d.frac   = shl[45:23];
      s2_d.guard  = shl[22];
      s2_d.sticky = |shl[21:0];
    end
  end

  // Stage 3: round, handle carry/overflow/flush and pack.
  logic          inc;
  logic          to_inf;
  logic          ix_n;
  logic [FW:0]   sum;
  logic [XW-1:0] ex_f;

  always_comb begin
    ix_n = s2_q.guard | s2_q.sticky;
    unique case (s2_q.rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s2_q.sign & ix_n;
      3'd3:    inc = ~s2_q.sign & ix_n;
      3'd4:    inc = s2_q.guard;
      default: inc = s2_q.guard & (s2_q.sticky | s2_q.frac[0]);
    endcase
    unique case (s2_q.rm)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = s2_q.sign;
      3'd3:    to_inf = ~s2_q.sign;
      default: to_inf = 1'b1;
    endcase
    // A carry out of the fraction leaves it zero and bumps the exponent;
    // a denormal with field 0 carries into field 1.
    sum  = {1'b0, s2_q.frac} + 24'(inc);
    ex_f = s2_q.ex + 10'(sum[FW]);

    o_d  = '0;
    ov_d = 1'b0;
    un_d = 1'b0;
    ix_d = 1'b0;
    unique case (s2_q.cls)
      CLS_SPECIAL: begin
        o_d  = {s2_q.sign, 8'hFF, s2_q.frac};
        ov_d = s2_q.over;
      end
      CLS_ZERO: begin
        o_d = {s2_q.sign, 31'd0};
      end
      CLS_FLUSH: begin
        o_d  = {s2_q.sign, 31'd0};
        un_d = 1'b1;
        ix_d = 1'b1;
      end
      default: begin
        if ($signed(ex_f) >= 10'sd255) begin
          o_d  = to_inf ? {s2_q.sign, 8'hFF, 23'd0} : {s2_q.sign, 8'hFE, 23'h7FFFFF};
          ov_d = 1'b1;
          ix_d = 1'b1;
        end else if (DENORM == 0 && ex_f == '0) begin
          o_d  = {s2_q.sign, 31'd0};
          un_d = 1'b1;
          ix_d = 1'b1;
        end else begin
          o_d  = {s2_q.sign, ex_f[EW-1:0], sum[FW-1:0]};
          ix_d = ix_n;
          un_d = (s2_q.ex == '0) & ix_n;
        end
      end
    endcase
  end

  // Pipeline registers; ce low freezes everything including valid flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      o_q   <= '0;
      ov_q  <= 1'b0;
      un_q  <= 1'b0;
      ix_q  <= 1'b0;
      vld_q <= 1'b0;
    end else if (bus.ce) begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      o_q   <= o_d;
      ov_q  <= ov_d;
      un_q  <= un_d;
      ix_q  <= ix_d;
      vld_q <= s2_q.vld;
    end
  end

  assign bus.o         = o_q;
  assign bus.vld_o     = vld_q;
  assign bus.overflow  = ov_q;
  assign bus.underflow = un_q;
  assign bus.inexact   = ix_q;

endmodule

// File: tb/tb_fp_norm_round32.sv
// Bench for fp_norm_round32: directed vectors, ce-stall and reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_fp_norm_round32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_norm_round32_if bus1 ();
  fp_norm_round32_if bus0 ();

  fp_norm_round32 #(.DENORM(1)) dut    (.clk(clk), .rst(rst), .bus(bus1));
  fp_norm_round32 #(.DENORM(0)) dut_fz (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct packed {
    logic [31:0] o;
    logic        ov;
    logic        un;
    logic        ix;
  } res_t;

  typedef struct packed {
    logic        fz;
    logic        sign;
    logic [7:0]  e;
    logic [47:0] m;
    logic        over;
    logic        under;
    logic [2:0]  rm;
    logic [31:0] xo;
    logic        xov;
    logic        xun;
    logic        xix;
  } vec_t;

  res_t        q1[$];
  res_t        q0[$];
  logic [35:0] prev1, prev0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en = 1'b0;

  // Value-level model: place the rounding point by exponent, round, repack.
  function automatic res_t model(input bit sign, input logic [7:0] e, input logic [47:0] m,
                                 input bit over, input bit under, input logic [2:0] rm,
                                 input bit denorm);
    res_t r;
    int E, p, eb, k, pre_field, field;
    longint unsigned mm, kept;
    bit g, st, inc, to_inf;
    r  = '0;
    mm = 64'(m);
    E  = (e == 8'd0) ? 1 : int'(e);
    if (e == 8'hFF || over) begin
      r.o  = {sign, 8'hFF, m[46:24]};
      r.ov = over;
      return r;
    end
    if (m == 48'd0) begin
      r.o = {sign, 31'd0};
      return r;
    end
    if (under) begin
      r.o  = {sign, 31'd0};
      r.un = 1'b1;
      r.ix = 1'b1;
      return r;
    end
    p = 0;
    for (int b = 0; b < 48; b++) if (m[b]) p = b;
    eb = E + p - 46;
    if (eb < 1) eb = 1;
    k  = eb - E + 23;   // bit of m that lands on the fraction LSB
    g  = 1'b0;
    st = 1'b0;
    if (k >= 0) begin
      kept = mm >> k;
      if (k >= 1) g = m[k-1];
      if (k >= 2) st = (mm & ((64'd1 << (k - 1)) - 64'd1)) != 64'd0;
    end else begin
      kept = mm << (-k);
    end
    pre_field = (kept >= 64'h800000) ? eb : 0;
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign & (g | st);
      3'd3:    inc = !sign & (g | st);
      3'd4:    inc = g;
      default: inc = g & (st | kept[0]);
    endcase
    kept = kept + 64'(inc);
    if (kept >= 64'h1000000) begin
      kept = kept >> 1;
      eb   = eb + 1;
    end
    field = (kept >= 64'h800000) ? eb : 0;
    r.ix  = g | st;
    if (field >= 255) begin
      to_inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? sign : (rm == 3'd3) ? !sign : 1'b1;
      r.o  = to_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF};
      r.ov = 1'b1;
      r.ix = 1'b1;
    end else if (!denorm && field == 0) begin
      r.o  = {sign, 31'd0};
      r.un = 1'b1;
      r.ix = 1'b1;
    end else begin
      r.o  = {sign, 8'(field), kept[22:0]};
      r.un = (pre_field == 0) && r.ix;
    end
    return r;
  endfunction

  function automatic vec_t mk(input bit fz, input bit sign, input logic [7:0] e,
                              input logic [47:0] m, input bit over, input bit under,
                              input logic [2:0] rm, input logic [31:0] xo,
                              input bit xov, input bit xun, input bit xix);
    vec_t v;
    v = '{fz, sign, e, m, over, under, rm, xo, xov, xun, xix};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit ce, input bit vld, input bit sign, input logic [7:0] e,
                        input logic [47:0] m, input bit over, input bit under,
                        input logic [2:0] rm);
    bus1.ce = ce; bus1.vld_i = vld; bus1.i = {sign, e, m};
    bus1.over_i = over; bus1.under_i = under; bus1.rm = rm;
    bus0.ce = ce; bus0.vld_i = vld; bus0.i = {sign, e, m};
    bus0.over_i = over; bus0.under_i = under; bus0.rm = rm;
    if (mon_en && ce && vld) begin
      q1.push_back(model(sign, e, m, over, under, rm, 1'b1));
      q0.push_back(model(sign, e, m, over, under, rm, 1'b0));
    end
  endtask

  task automatic rand_in(input bit ce, input bit vld);
    bit sign, over, under;
    logic [7:0] e;
    logic [47:0] m;
    logic [2:0] rm;
    int r;
    sign = 1'($urandom);
    r = int'($urandom % 8);
    if (r == 0)      e = 8'($urandom_range(0, 3));
    else if (r == 1) e = 8'($urandom_range(253, 254));
    else if (r == 2) e = 8'hFF;
    else             e = 8'($urandom_range(1, 254));
    m = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 47);
    if ($urandom % 4 == 0) m = m & 48'hFFFF_FFC0_0000;
    if ($urandom % 20 == 0) m = 48'd0;
    over  = ($urandom % 32) == 0;
    under = ($urandom % 16) == 0;
    rm    = 3'($urandom);
    set_in(ce, vld, sign, e, m, over, under, rm);
  endtask

  task automatic mon(input bit which, input bit ce_edge);
    res_t g, x;
    logic v;
    int qs;
    if (which) begin
      g = {bus1.o, bus1.overflow, bus1.underflow, bus1.inexact};
      v = bus1.vld_o;
      qs = q1.size();
    end else begin
      g = {bus0.o, bus0.overflow, bus0.underflow, bus0.inexact};
      v = bus0.vld_o;
      qs = q0.size();
    end
    if (ce_edge) begin
      if (v) begin
        if (qs == 0) begin
          check($sformatf("spurious_vld_o_d%0d", which), 64'(v), 64'(0));
        end else begin
          if (which) x = q1.pop_front();
          else       x = q0.pop_front();
          check($sformatf("result_d%0d", which), 64'(g), 64'(x));
        end
      end
    end else begin
      check($sformatf("hold_d%0d", which), 64'({v, g}), 64'(which ? prev1 : prev0));
    end
  endtask

  task automatic cycle();
    bit ce_edge;
    @(posedge clk);
    #1;
    ce_edge = bus1.ce;
    if (mon_en) begin
      mon(1'b1, ce_edge);
      mon(1'b0, ce_edge);
    end
    prev1 = {bus1.vld_o, bus1.o, bus1.overflow, bus1.underflow, bus1.inexact};
    prev0 = {bus0.vld_o, bus0.o, bus0.overflow, bus0.underflow, bus0.inexact};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[22];
    vec_t v;
    res_t g;

    tbl[0]  = mk(0, 0, 8'h7F, 48'h4000_0000_0000, 0, 0, 3'd0, 32'h3F800000, 0, 0, 0);
    tbl[1]  = mk(0, 0, 8'h7F, 48'h8000_0000_0000, 0, 0, 3'd0, 32'h40000000, 0, 0, 0);
    tbl[2]  = mk(0, 0, 8'h7F, 48'h4000_0040_0000, 0, 0, 3'd0, 32'h3F800000, 0, 0, 1);
    tbl[3]  = mk(0, 0, 8'h7F, 48'h4000_00C0_0000, 0, 0, 3'd0, 32'h3F800002, 0, 0, 1);
    tbl[4]  = mk(0, 0, 8'h7F, 48'h4000_0040_0000, 0, 0, 3'd3, 32'h3F800001, 0, 0, 1);
    tbl[5]  = mk(0, 0, 8'h7F, 48'h4000_00C0_0000, 0, 0, 3'd3, 32'h3F800002, 0, 0, 1);
    tbl[6]  = mk(0, 0, 8'hFE, 48'h8000_0000_0000, 0, 0, 3'd0, 32'h7F800000, 1, 0, 1);
    tbl[7]  = mk(0, 0, 8'hFE, 48'h8000_0000_0000, 0, 0, 3'd1, 32'h7F7FFFFF, 1, 0, 1);
    tbl[8]  = mk(0, 1, 8'hFE, 48'h8000_0000_0000, 0, 0, 3'd3, 32'hFF7FFFFF, 1, 0, 1);
    tbl[9]  = mk(0, 1, 8'hFE, 48'h8000_0000_0000, 0, 0, 3'd2, 32'hFF800000, 1, 0, 1);
    tbl[10] = mk(0, 0, 8'h01, 48'h2000_0000_0000, 0, 0, 3'd0, 32'h00400000, 0, 0, 0);
    tbl[11] = mk(1, 0, 8'h01, 48'h2000_0000_0000, 0, 0, 3'd0, 32'h00000000, 0, 1, 1);
    tbl[12] = mk(0, 1, 8'h7F, 48'h4000_0000_0000, 0, 1, 3'd0, 32'h80000000, 0, 1, 1);
    tbl[13] = mk(0, 0, 8'hFF, 48'hC000_0000_0000, 0, 0, 3'd0, 32'h7FC00000, 0, 0, 0);
    tbl[14] = mk(0, 1, 8'h7F, 48'h8000_0000_0000, 1, 0, 3'd0, 32'hFF800000, 1, 0, 0);
    tbl[15] = mk(0, 1, 8'h55, 48'h0000_0000_0000, 0, 0, 3'd0, 32'h80000000, 0, 0, 0);
    tbl[16] = mk(0, 0, 8'h01, 48'h3FFF_FFC0_0000, 0, 0, 3'd0, 32'h00800000, 0, 1, 1);
    tbl[17] = mk(0, 1, 8'h7F, 48'h4000_0040_0000, 0, 0, 3'd2, 32'hBF800001, 0, 0, 1);
    tbl[18] = mk(0, 0, 8'h7F, 48'h4000_0040_0000, 0, 0, 3'd4, 32'h3F800001, 0, 0, 1);
    tbl[19] = mk(0, 0, 8'h7F, 48'h4000_0040_0000, 0, 0, 3'd7, 32'h3F800000, 0, 0, 1);
    tbl[20] = mk(0, 0, 8'h80, 48'h0100_0000_0000, 0, 0, 3'd0, 32'h3D000000, 0, 0, 0);
    tbl[21] = mk(0, 0, 8'h00, 48'h4000_0000_0000, 0, 0, 3'd0, 32'h00800000, 0, 0, 0);

    // Reset with a valid word presented: nothing may leave the pipeline.
    rst = 1'b1;
    set_in(1, 1, 0, 8'h7F, 48'h4000_0000_0000, 0, 0, 3'd0);
    repeat (4) cycle();
    check("rst_vld_d1", 64'(bus1.vld_o), 64'(0));
    check("rst_out_d1", 64'({bus1.o, bus1.overflow, bus1.underflow, bus1.inexact}), 64'(0));
    check("rst_vld_d0", 64'(bus0.vld_o), 64'(0));
    check("rst_out_d0", 64'({bus0.o, bus0.overflow, bus0.underflow, bus0.inexact}), 64'(0));
    rst = 1'b0;
    set_in(1, 0, 0, 8'd0, 48'd0, 0, 0, 3'd0);
    repeat (3) cycle();

    // Directed vectors with exact latency.
    foreach (tbl[t]) begin
      v = tbl[t];
      set_in(1, 1, v.sign, v.e, v.m, v.over, v.under, v.rm);
      cycle();
      set_in(1, 0, 0, 8'd0, 48'd0, 0, 0, 3'd0);
      cycle();
      check($sformatf("vec%0d_early_vld", t), 64'(v.fz ? bus0.vld_o : bus1.vld_o), 64'(0));
      cycle();
      check($sformatf("vec%0d_vld", t), 64'(v.fz ? bus0.vld_o : bus1.vld_o), 64'(1));
      if (v.fz) g = {bus0.o, bus0.overflow, bus0.underflow, bus0.inexact};
      else      g = {bus1.o, bus1.overflow, bus1.underflow, bus1.inexact};
      check($sformatf("vec%0d_result", t), 64'(g), 64'({v.xo, v.xov, v.xun, v.xix}));
    end

    // Back-to-back stream with a two-cycle ce stall in the middle.
    mon_en = 1'b1;
    for (int w = 0; w < 8; w++) begin
      if (w == 3) begin
        repeat (2) begin
          rand_in(0, 1);
          cycle();
        end
      end
      rand_in(1, 1);
      cycle();
    end
    set_in(1, 0, 0, 8'd0, 48'd0, 0, 0, 3'd0);
    repeat (4) cycle();
    check("stall_drain_d1", 64'(q1.size()), 64'(0));
    check("stall_drain_d0", 64'(q0.size()), 64'(0));

    // Reset with two words in flight.
    rand_in(1, 1);
    cycle();
    rand_in(1, 1);
    cycle();
    set_in(1, 0, 0, 8'd0, 48'd0, 0, 0, 3'd0);
    rst = 1'b1;
    #1;
    check("rst_flight_vld_d1", 64'(bus1.vld_o), 64'(0));
    check("rst_flight_vld_d0", 64'(bus0.vld_o), 64'(0));
    check("rst_flight_o_d1", 64'(bus1.o), 64'(0));
    check("rst_flight_o_d0", 64'(bus0.o), 64'(0));
    q1.delete();
    q0.delete();
    repeat (2) cycle();
    rst = 1'b0;
    repeat (5) cycle();
    set_in(1, 1, 0, 8'h7F, 48'h8000_0000_0000, 0, 0, 3'd0);
    cycle();
    set_in(1, 0, 0, 8'd0, 48'd0, 0, 0, 3'd0);
    repeat (4) cycle();
    check("rst_after_drain_d1", 64'(q1.size()), 64'(0));
    check("rst_after_drain_d0", 64'(q0.size()), 64'(0));

    // Randomized traffic with random ce and valid gaps.
    for (int c = 0; c < 3000; c++) begin
      rand_in(($urandom % 5) != 0, ($urandom % 4) != 0);
      cycle();
    end
    set_in(1, 0, 0, 8'd0, 48'd0, 0, 0, 3'd0);
    repeat (5) cycle();
    check("rand_drain_d1", 64'(q1.size()), 64'(0));
    check("rand_drain_d0", 64'(q0.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
